// File: rtl/cpu_pkg.sv
// Shared CPU types: word and register-index widths
// plus the writeback request bundle.
package cpu_pkg;

    localparam int DATA_W    = 16;
    localparam int REG_IDX_W = 4;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0]    word_t;

    typedef struct packed {
        reg_idx_t rd;
        word_t    data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO with circular pointers and an
// occupancy count; DEPTH must be a power of two >= 2.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Storage write; contents need no reset, count guards them
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/rf_writeback.sv
// Register-file write port master: merges ALU and load
// results, tracks pending writes, forwards the live write.
module rf_writeback
    import cpu_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NREGS    = 16,
    parameter int LQ_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic [$clog2(NREGS)-1:0] issue_rd,
    output logic                     issue_ready,
    input  logic                     alu_valid,
    input  logic [$clog2(NREGS)-1:0] alu_rd,
    input  logic [DATA_W-1:0]        alu_data,
    output logic                     alu_ready,
    input  logic                     ld_valid,
    input  logic [$clog2(NREGS)-1:0] ld_rd,
    input  logic [DATA_W-1:0]        ld_data,
    output logic                     ld_ready,
    input  logic [$clog2(NREGS)-1:0] rs1,
    input  logic [$clog2(NREGS)-1:0] rs2,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
    output logic                     fwd1_hit,
    output logic                     fwd2_hit,
    output logic [DATA_W-1:0]        fwd1_data,
    output logic [DATA_W-1:0]        fwd2_data,
    output logic                     rf_write_enable,
    output logic [$clog2(NREGS)-1:0] rf_write_reg,
    output logic [DATA_W-1:0]        rf_write_data,
    output logic [NREGS-1:0]         pending
);

    wb_req_t          alu_req;
    wb_req_t          ld_req;
    wb_req_t          ld_head;
    wb_req_t          sel_req;
    logic             fifo_full;
    logic             fifo_empty;
    logic             sel_ld;
    logic             sel_valid;
    logic [NREGS-1:0] pend_nxt;

    assign alu_req = '{rd: alu_rd, data: alu_data};
    assign ld_req  = '{rd: ld_rd,  data: ld_data};

    wb_fifo #(
        .DEPTH (LQ_DEPTH),
        .WIDTH ($bits(wb_req_t))
    ) u_ld_q (
        .clk       (clk),
        .rst       (rst),
        .push      (ld_valid && ld_ready),
        .push_data (ld_req),
        .pop       (sel_ld),
        .pop_data  (ld_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ALU wins unless the load queue is full, bounding starvation
    assign sel_ld    = fifo_full || (!alu_valid && !fifo_empty);
    assign sel_valid = sel_ld || alu_valid;
    assign sel_req   = sel_ld ? ld_head : alu_req;
    assign alu_ready = !fifo_full;
    assign ld_ready  = !fifo_full;

    assign issue_ready = !pending[issue_rd];

    assign fwd1_hit  = rf_write_enable && (rf_write_reg == rs1);
    assign fwd2_hit  = rf_write_enable && (rf_write_reg == rs2);
    assign fwd1_data = fwd1_hit ? rf_write_data : '0;
    assign fwd2_data = fwd2_hit ? rf_write_data : '0;
    assign rs1_busy  = pending[rs1] && !fwd1_hit;
    assign rs2_busy  = pending[rs2] && !fwd2_hit;

    // Next scoreboard: clear the retiring reg, then a new issue sets
    always_comb begin
        pend_nxt = pending;
        if (sel_valid) begin
            pend_nxt[sel_req.rd] = 1'b0;
        end
        if (issue_valid && issue_ready) begin
            pend_nxt[issue_rd] = 1'b1;
        end
    end

    // Register the selected result and the scoreboard together
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_write_enable <= 1'b0;
            rf_write_reg    <= '0;
            rf_write_data   <= '0;
            pending         <= '0;
        end else begin
            rf_write_enable <= sel_valid;
            pending         <= pend_nxt;
            if (sel_valid) begin
                rf_write_reg  <= sel_req.rd;
                rf_write_data <= sel_req.data;
            end
        end
    end

endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback: per-cycle vector table
// plus hand sequences for forwarding and mid-run reset.
module tb_rf_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [3:0]  issue_rd;
    logic        issue_ready;
    logic        alu_valid;
    logic [3:0]  alu_rd;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [3:0]  ld_rd;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        fwd1_hit;
    logic        fwd2_hit;
    logic [15:0] fwd1_data;
    logic [15:0] fwd2_data;
    logic        rf_write_enable;
    logic [3:0]  rf_write_reg;
    logic [15:0] rf_write_data;
    logic [15:0] pending;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rf_writeback dut (
        .clk             (clk),
        .rst             (rst),
        .issue_valid     (issue_valid),
        .issue_rd        (issue_rd),
        .issue_ready     (issue_ready),
        .alu_valid       (alu_valid),
        .alu_rd          (alu_rd),
        .alu_data        (alu_data),
        .alu_ready       (alu_ready),
        .ld_valid        (ld_valid),
        .ld_rd           (ld_rd),
        .ld_data         (ld_data),
        .ld_ready        (ld_ready),
        .rs1             (rs1),
        .rs2             (rs2),
        .rs1_busy        (rs1_busy),
        .rs2_busy        (rs2_busy),
        .fwd1_hit        (fwd1_hit),
        .fwd2_hit        (fwd2_hit),
        .fwd1_data       (fwd1_data),
        .fwd2_data       (fwd2_data),
        .rf_write_enable (rf_write_enable),
        .rf_write_reg    (rf_write_reg),
        .rf_write_data   (rf_write_data),
        .pending         (pending)
    );

    typedef struct {
        logic        iv;
        logic [3:0]  ird;
        logic        av;
        logic [3:0]  ard;
        logic [15:0] ad;
        logic        lv;
        logic [3:0]  lrd;
        logic [15:0] ldd;
        logic        e_ardy;
        logic        e_lrdy;
        logic        e_irdy;
        logic        e_we;
        logic [3:0]  e_reg;
        logic [15:0] e_data;
        logic [15:0] e_pend;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        issue_rd    = 4'd0;
        alu_valid   = 1'b0;
        alu_rd      = 4'd0;
        alu_data    = 16'h0;
        ld_valid    = 1'b0;
        ld_rd       = 4'd0;
        ld_data     = 16'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ALU write to r3 after issuing r3
        tbl[0]  = '{1,3, 0,0,16'h0,    0,0,16'h0,    1,1,1, 0,0, 16'h0,    16'h0008};
        tbl[1]  = '{0,0, 1,3,16'hBEEF, 0,0,16'h0,    1,1,1, 1,3, 16'hBEEF, 16'h0000};
        tbl[2]  = '{0,0, 0,0,16'h0,    0,0,16'h0,    1,1,1, 0,3, 16'hBEEF, 16'h0000};
        // ALU and load collide
        tbl[3]  = '{0,0, 1,1,16'h0011, 1,2,16'h0022, 1,1,1, 1,1, 16'h0011, 16'h0000};
        tbl[4]  = '{0,0, 0,0,16'h0,    0,0,16'h0,    1,1,1, 1,2, 16'h0022, 16'h0000};
        tbl[5]  = '{0,0, 0,0,16'h0,    0,0,16'h0,    1,1,1, 0,2, 16'h0022, 16'h0000};
        // Continuous ALU traffic with three loads
        tbl[6]  = '{0,0, 1,10,16'hA00A, 1,4,16'h4444, 1,1,1, 1,10,16'hA00A, 16'h0000};
        tbl[7]  = '{0,0, 1,11,16'hB00B, 1,5,16'h5555, 1,1,1, 1,11,16'hB00B, 16'h0000};
        tbl[8]  = '{0,0, 1,12,16'hC00C, 1,6,16'h6666, 0,0,1, 1,4, 16'h4444, 16'h0000};
        tbl[9]  = '{0,0, 1,12,16'hC00C, 1,6,16'h6666, 1,1,1, 1,12,16'hC00C, 16'h0000};
        tbl[10] = '{0,0, 1,13,16'hD00D, 0,0,16'h0,    0,0,1, 1,5, 16'h5555, 16'h0000};
        tbl[11] = '{0,0, 1,13,16'hD00D, 0,0,16'h0,    1,1,1, 1,13,16'hD00D, 16'h0000};
        tbl[12] = '{0,0, 0,0,16'h0,    0,0,16'h0,    1,1,1, 1,6, 16'h6666, 16'h0000};
        tbl[13] = '{0,0, 0,0,16'h0,    0,0,16'h0,    1,1,1, 0,6, 16'h6666, 16'h0000};
        // Same-cycle set/clear on r9, then blocked re-issue
        tbl[14] = '{1,9, 0,0,16'h0,    0,0,16'h0,    1,1,1, 0,6, 16'h6666, 16'h0200};
        tbl[15] = '{0,0, 1,9,16'h0909, 0,0,16'h0,    1,1,1, 1,9, 16'h0909, 16'h0000};
        tbl[16] = '{1,9, 1,9,16'h0A0A, 0,0,16'h0,    1,1,1, 1,9, 16'h0A0A, 16'h0200};
        tbl[17] = '{1,9, 0,0,16'h0,    0,0,16'h0,    1,1,0, 0,9, 16'h0A0A, 16'h0200};

        idle();
        rs1 = 4'd0;
        rs2 = 4'd0;
        rst = 1'b1;
        #1;
        chk("ld_ready_in_rst", ld_ready, 1);
        chk("alu_ready_in_rst", alu_ready, 1);
        step();
        step();
        chk("rst_we", rf_write_enable, 0);
        chk("rst_reg", rf_write_reg, 0);
        chk("rst_data", rf_write_data, 0);
        chk("rst_pend", pending, 0);
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_alu_ready", alu_ready, 1);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            issue_valid = tbl[i].iv;
            issue_rd    = tbl[i].ird;
            alu_valid   = tbl[i].av;
            alu_rd      = tbl[i].ard;
            alu_data    = tbl[i].ad;
            ld_valid    = tbl[i].lv;
            ld_rd       = tbl[i].lrd;
            ld_data     = tbl[i].ldd;
            #1;
            chk($sformatf("v%0d_alu_ready", i), alu_ready, tbl[i].e_ardy);
            chk($sformatf("v%0d_ld_ready", i), ld_ready, tbl[i].e_lrdy);
            chk($sformatf("v%0d_issue_ready", i), issue_ready, tbl[i].e_irdy);
            step();
            chk($sformatf("v%0d_we", i), rf_write_enable, tbl[i].e_we);
            chk($sformatf("v%0d_reg", i), rf_write_reg, tbl[i].e_reg);
            chk($sformatf("v%0d_data", i), rf_write_data, tbl[i].e_data);
            chk($sformatf("v%0d_pend", i), pending, tbl[i].e_pend);
        end
        idle();

        // Scoreboard busy and forwarding on r7
        issue_valid = 1'b1;
        issue_rd    = 4'd7;
        step();
        idle();
        chk("r7_pend", pending, 16'h0280);
        rs1 = 4'd7;
        rs2 = 4'd9;
        #1;
        chk("r7_rs1_busy", rs1_busy, 1);
        chk("r7_fwd1_pre", fwd1_hit, 0);
        chk("r9_rs2_busy", rs2_busy, 1);
        alu_valid = 1'b1;
        alu_rd    = 4'd7;
        alu_data  = 16'h1234;
        step();
        idle();
        chk("fwd1_hit", fwd1_hit, 1);
        chk("fwd1_data", fwd1_data, 16'h1234);
        chk("fwd_rs1_busy", rs1_busy, 0);
        chk("fwd2_hit", fwd2_hit, 0);
        chk("fwd2_data", fwd2_data, 16'h0);
        chk("fwd_rs2_busy", rs2_busy, 1);
        chk("fwd_pend", pending, 16'h0200);
        step();
        chk("fwd1_hit_after", fwd1_hit, 0);
        chk("fwd1_data_after", fwd1_data, 16'h0);
        chk("rs1_busy_after", rs1_busy, 0);

        // Build pending=00F0 with two loads queued, then reset
        alu_valid   = 1'b1;
        alu_rd      = 4'd9;
        alu_data    = 16'h0999;
        issue_valid = 1'b1;
        issue_rd    = 4'd4;
        step();
        alu_valid = 1'b0;
        issue_rd  = 4'd5;
        step();
        issue_rd = 4'd6;
        step();
        issue_rd  = 4'd7;
        alu_valid = 1'b1;
        alu_rd    = 4'd0;
        alu_data  = 16'h0000;
        ld_valid  = 1'b1;
        ld_rd     = 4'd1;
        ld_data   = 16'h0101;
        step();
        issue_valid = 1'b0;
        ld_rd       = 4'd2;
        ld_data     = 16'h0202;
        step();
        idle();
        #1;
        chk("pre_rst_pend", pending, 16'h00F0);
        chk("pre_rst_ld_full", ld_ready, 0);
        rst = 1'b1;
        step();
        chk("mid_rst_pend", pending, 16'h0);
        chk("mid_rst_ld_ready", ld_ready, 1);
        chk("mid_rst_alu_ready", alu_ready, 1);
        chk("mid_rst_we", rf_write_enable, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("post_rst_we%0d", i), rf_write_enable, 0);
        end
        chk("post_rst_pend", pending, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
